// File: rtl/adc_lut_interp.sv
// rtl/adc_lut_interp.sv - piecewise-linear ADC code to fixed-point value converter
// Linear search of a descending runtime LUT, then restoring-divider interpolation within the hit segment.
module adc_lut_interp #(
  parameter int ADC_W     = 12,
  parameter int OUT_W     = 16,
  parameter int LUT_DEPTH = 22,
  parameter int LUT_AW    = 5,
  parameter int STEP      = 1280,
  parameter int OUT_BASE  = 0,
  parameter int CH_W      = 2
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADC_W-1:0]  i_adc_value,
  input  logic [CH_W-1:0]   i_ch,
  output logic              o_ready,
  input  logic              i_lut_we,
  input  logic [LUT_AW-1:0] i_lut_addr,
  input  logic [ADC_W-1:0]  i_lut_data,
  output logic              o_done,
  output logic [CH_W-1:0]   o_ch,
  output logic [OUT_W-1:0]  o_value,
  output logic              o_clip_top,
  output logic              o_clip_bot
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DIV, S_OUT} state_t;

  localparam int DVD_W = ADC_W + 16;
  localparam int RW    = (ADC_W + OUT_W > DVD_W) ? (ADC_W + OUT_W) : DVD_W;
  localparam int CW    = $clog2(OUT_W + 1);
  localparam logic [OUT_W-1:0]  TOP_VAL  = OUT_W'(OUT_BASE);
  localparam logic [OUT_W-1:0]  BOT_VAL  = OUT_W'(OUT_BASE + (LUT_DEPTH - 1) * STEP);
  localparam logic [OUT_W-1:0]  STEP_V   = OUT_W'(STEP);
  localparam logic [LUT_AW-1:0] LAST_IDX = LUT_AW'(LUT_DEPTH - 1);
  localparam logic [LUT_AW-1:0] ONE_IDX  = LUT_AW'(1);

  state_t state, state_nx;

  logic [ADC_W-1:0]  lut [LUT_DEPTH];
  logic [ADC_W-1:0]  code_q;
  logic [CH_W-1:0]   ch_q;
  logic [LUT_AW-1:0] n_idx;
  logic [OUT_W-1:0]  seg_base;
  logic [RW-1:0]     rem;
  logic [RW-1:0]     dsh;
  logic [OUT_W-1:0]  quo;
  logic [CW-1:0]     dcnt;
  logic              div_zero;

  logic [LUT_AW-1:0] prev_idx;
  logic [ADC_W-1:0]  lut_cur, lut_prev, span, divisor;
  logic [DVD_W-1:0]  dividend;
  logic              clip_t, clip_b, hit, div_ge, div_last, lut_wr;
  logic [OUT_W-1:0]  quo_nx;

  // Search compares against entry n; the segment ends at entry n-1, known to be above the code.
  always_comb begin
    prev_idx = n_idx - ONE_IDX;
    lut_cur  = lut[n_idx];
    lut_prev = lut[prev_idx];
    clip_t   = (n_idx == ONE_IDX) && (code_q >= lut[0]);
    clip_b   = (n_idx == ONE_IDX) && !clip_t && (code_q <= lut[LUT_DEPTH-1]);
    hit      = (code_q >= lut_cur) || (n_idx == LAST_IDX);
    span     = lut_prev - code_q;
    divisor  = lut_prev - lut_cur;
    dividend = DVD_W'(span) * DVD_W'(STEP);
    div_ge   = (rem >= dsh);
    quo_nx   = {quo[OUT_W-2:0], div_ge};
    div_last = (dcnt == CW'(OUT_W - 1));
    lut_wr   = i_lut_we && (state == S_IDLE) && (int'(i_lut_addr) < LUT_DEPTH);
  end

  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (i_valid) state_nx = S_SEARCH;
      S_SEARCH: begin
        if (clip_t || clip_b) state_nx = S_OUT;
        else if (hit)         state_nx = S_DIV;
      end
      S_DIV:    if (div_last) state_nx = S_OUT;
      S_OUT:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == S_IDLE);
    o_done  = (state == S_OUT);
  end

  // Result registers load on the edge entering OUT so they are valid while o_done is high.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LUT_DEPTH; k++) lut[k] <= '0;
      code_q     <= '0;
      ch_q       <= '0;
      n_idx      <= ONE_IDX;
      seg_base   <= '0;
      rem        <= '0;
      dsh        <= '0;
      quo        <= '0;
      dcnt       <= '0;
      div_zero   <= 1'b0;
      o_ch       <= '0;
      o_value    <= '0;
      o_clip_top <= 1'b0;
      o_clip_bot <= 1'b0;
    end else begin
      if (lut_wr) lut[i_lut_addr] <= i_lut_data;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            code_q   <= i_adc_value;
            ch_q     <= i_ch;
            n_idx    <= ONE_IDX;
            seg_base <= TOP_VAL;
          end
        end
        S_SEARCH: begin
          if (clip_t) begin
            o_value    <= TOP_VAL;
            o_ch       <= ch_q;
            o_clip_top <= 1'b1;
            o_clip_bot <= 1'b0;
          end else if (clip_b) begin
            o_value    <= BOT_VAL;
            o_ch       <= ch_q;
            o_clip_top <= 1'b0;
            o_clip_bot <= 1'b1;
          end else if (hit) begin
            rem      <= RW'(dividend);
            dsh      <= RW'(divisor) << (OUT_W - 1);
            div_zero <= (divisor == '0);
            quo      <= '0;
            dcnt     <= '0;
          end else begin
            n_idx    <= n_idx + ONE_IDX;
            seg_base <= seg_base + STEP_V;
          end
        end
        S_DIV: begin
          if (div_ge) rem <= rem - dsh;
          quo  <= quo_nx;
          dsh  <= dsh >> 1;
          dcnt <= dcnt + CW'(1);
          if (div_last) begin
            o_value    <= seg_base + (div_zero ? '0 : quo_nx);
            o_ch       <= ch_q;
            o_clip_top <= 1'b0;
            o_clip_bot <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
